// File: rtl/pc_next_unit_pkg.sv
// +-----------------------------------------------------------------------+
// | pc_next_unit_pkg : state encoding and PC constants for pc_next_unit   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package pc_next_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } pc_state_e;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pc_next_unit_target_gen.sv
// +-----------------------------------------------------------------------+
// | pc_target_gen : combinational next-PC candidates and priority select  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pc_target_gen
    import pc_next_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] pc_i,
    input  logic         branch_i,
    input  logic         brflag_i,
    input  logic [15:0]  imm_i,
    input  logic         jump_i,
    input  logic [25:0]  jaddr_i,
    input  logic         jr_i,
    input  logic [N-1:0] rs_i,
    output logic [N-1:0] pc4_o,
    output logic [N-1:0] next_pc_o,
    output logic         redirect_o,
    output logic         misaligned_o
);

    logic [N-1:0] pc4;
    logic [N-1:0] br_off;
    logic [N-1:0] btgt;
    logic [N-1:0] jtgt;
    logic [N-1:0] next_pc;

    assign pc4    = pc_i + N'(PC_INCR);
    // Word offset sign-extended and scaled to bytes in one step.
    assign br_off = {{(N-18){imm_i[15]}}, imm_i, 2'b00};
    assign btgt   = pc4 + br_off;
    assign jtgt   = {pc4[N-1:28], jaddr_i, 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jr_i) begin
            next_pc = rs_i;
        end else if (jump_i) begin
            next_pc = jtgt;
        end else if (branch_i && brflag_i) begin
            next_pc = btgt;
        end
    end

    assign pc4_o        = pc4;
    assign next_pc_o    = next_pc;
    assign redirect_o   = jr_i | jump_i | (branch_i & brflag_i);
    assign misaligned_o = |next_pc[1:0];

endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
// +-----------------------------------------------------------------------+
// | pc_next_unit : PC register, run/halt/fault control, retire counter    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC),
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             brflag_i,
    input  logic [15:0]      imm_i,
    input  logic             jump_i,
    input  logic [25:0]      jaddr_i,
    input  logic             jr_i,
    input  logic [N-1:0]     rs_i,
    input  logic             halt_i,
    output logic [N-1:0]     pc_o,
    output logic [N-1:0]     pc4_o,
    output logic             taken_o,
    output logic [1:0]       state_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] retired_o
);

    pc_state_e        state_q, state_d;
    logic [N-1:0]     pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [N-1:0]     next_pc;
    logic             redirect;
    logic             misaligned;
    logic             advance;

    pc_target_gen #(
        .N (N)
    ) u_target_gen (
        .pc_i         (pc_q),
        .branch_i     (branch_i),
        .brflag_i     (brflag_i),
        .imm_i        (imm_i),
        .jump_i       (jump_i),
        .jaddr_i      (jaddr_i),
        .jr_i         (jr_i),
        .rs_i         (rs_i),
        .pc4_o        (pc4_o),
        .next_pc_o    (next_pc),
        .redirect_o   (redirect),
        .misaligned_o (misaligned)
    );

    assign advance = (state_q == ST_RUN) && !stall_i;

    // A misaligned target wins over halt; halt wins over any redirect.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fault_d   = fault_q;
        retired_d = retired_q;
        if (advance) begin
            if (misaligned) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end else if (halt_i) begin
                state_d   = ST_HALT;
                retired_d = retired_q + CNT_W'(1);
            end else begin
                pc_d      = next_pc;
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign pc_o      = pc_q;
    assign taken_o   = advance & redirect;
    assign state_o   = state_q;
    assign fault_o   = fault_q;
    assign retired_o = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// +-----------------------------------------------------------------------+
// | tb_pc_next_unit : scoreboard bench with reference model for the PC    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        rst_ni, stall_i, branch_i, brflag_i, jump_i, jr_i, halt_i;
    logic [15:0] imm_i;
    logic [25:0] jaddr_i;
    logic [31:0] rs_i;
    logic [31:0] pc_o, pc4_o, retired_o;
    logic        taken_o, fault_o;
    logic [1:0]  state_o;

    // Second instance with a reset vector at the top of the address space.
    logic        rst_w_n;
    logic        zero_b = 1'b0;
    logic [15:0] zero16 = '0;
    logic [25:0] zero26 = '0;
    logic [31:0] zero32 = '0;
    logic [31:0] pc_w, pc4_w, ret_w;
    logic        taken_w, fault_w;
    logic [1:0]  state_w;

    always #5 clk = ~clk;

    pc_next_unit #(.N(32), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i), .branch_i(branch_i),
        .brflag_i(brflag_i), .imm_i(imm_i), .jump_i(jump_i), .jaddr_i(jaddr_i),
        .jr_i(jr_i), .rs_i(rs_i), .halt_i(halt_i), .pc_o(pc_o), .pc4_o(pc4_o),
        .taken_o(taken_o), .state_o(state_o), .fault_o(fault_o), .retired_o(retired_o)
    );

    pc_next_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_w (
        .clk_i(clk), .rst_ni(rst_w_n), .stall_i(zero_b), .branch_i(zero_b),
        .brflag_i(zero_b), .imm_i(zero16), .jump_i(zero_b), .jaddr_i(zero26),
        .jr_i(zero_b), .rs_i(zero32), .halt_i(zero_b), .pc_o(pc_w), .pc4_o(pc4_w),
        .taken_o(taken_w), .state_o(state_w), .fault_o(fault_w), .retired_o(ret_w)
    );

    typedef struct {
        logic [31:0] pc4;
        logic        taken;
        logic [31:0] pc;
        int          state;
        logic        fault;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    bit          have;
    int          checks   = 0;
    int          failures = 0;

    // Reference model: 0=RUN 1=HALT 2=FAULT
    logic [31:0] m_pc;
    int          m_state;
    logic [31:0] m_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst_n, input logic stall, input logic br,
                         input logic flag, input logic [15:0] imm, input logic jmp,
                         input logic [25:0] ja, input logic jr, input logic [31:0] rs,
                         input logic halt);
        exp_t        e;
        logic [31:0] p4, tgt;
        int          off;
        @(negedge clk);
        rst_ni = rst_n; stall_i = stall; branch_i = br; brflag_i = flag; imm_i = imm;
        jump_i = jmp; jaddr_i = ja; jr_i = jr; rs_i = rs; halt_i = halt;
        p4      = m_pc + 32'd4;
        e.pc4   = p4;
        e.taken = (m_state == 0) && !stall && (jr || jmp || (br && flag));
        if (!rst_n) begin
            m_pc = 32'h0; m_state = 0; m_ret = 32'h0;
        end else if (m_state == 0 && !stall) begin
            off = $signed(imm);
            if (jr)               tgt = rs;
            else if (jmp)         tgt = {p4[31:28], ja, 2'b00};
            else if (br && flag)  tgt = p4 + 32'(off * 4);
            else                  tgt = p4;
            if (tgt % 4 != 0) begin
                m_state = 2;
            end else if (halt) begin
                m_state = 1; m_ret = m_ret + 1;
            end else begin
                m_pc = tgt; m_ret = m_ret + 1;
            end
        end
        e.pc    = m_pc;
        e.state = m_state;
        e.fault = (m_state == 2);
        e.ret   = m_ret;
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    endtask

    // Monitor: combinational outputs checked mid-cycle, registered ones after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            have = sb.size() > 0;
            if (have) begin
                cur = sb[0];
                chk("taken_o", 64'(taken_o), 64'(cur.taken));
                chk("pc4_o", 64'(pc4_o), 64'(cur.pc4));
                @(posedge clk);
                #1;
                chk("pc_o", 64'(pc_o), 64'(cur.pc));
                chk("state_o", 64'(state_o), 64'(cur.state));
                chk("fault_o", 64'(fault_o), 64'(cur.fault));
                chk("retired_o", 64'(retired_o), 64'(cur.ret));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] rs;
        logic        h;
        rst_ni = 0; stall_i = 0; branch_i = 0; brflag_i = 0; imm_i = '0;
        jump_i = 0; jaddr_i = '0; jr_i = 0; rs_i = '0; halt_i = 0; rst_w_n = 0;
        m_pc = 32'h0; m_state = 0; m_ret = 32'h0;
        repeat (2) @(posedge clk);

        drive(0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        repeat (4) idle();
        drive(1, 0, 1, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0);          // 0x10 -> 0x04
        drive(1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h10, 0);
        drive(1, 0, 1, 0, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0);          // not taken -> 0x14
        drive(1, 0, 1, 1, 16'h0005, 1, 26'h3, 1, 32'h100, 0);        // jr wins
        drive(1, 0, 0, 0, 16'h0, 1, 26'h40, 0, 32'h0, 0);            // jump -> 0x100
        drive(1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h102, 0);           // misaligned
        drive(1, 0, 1, 1, 16'h0010, 1, 26'h7, 1, 32'h200, 1);
        idle();
        drive(0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h20, 0);
        drive(1, 1, 0, 0, 16'h0, 1, 26'h9, 0, 32'h0, 1);             // stall masks all
        drive(1, 1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h103, 0);
        drive(1, 0, 0, 0, 16'h0, 1, 26'h50, 0, 32'h0, 1);            // halt beats jump
        drive(1, 0, 1, 1, 16'h0004, 1, 26'h1, 0, 32'h0, 0);
        idle();
        drive(0, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);

        for (int i = 0; i < 300; i++) begin
            h  = ($urandom % 30) == 0;
            rs = $urandom & 32'hFFFF_FFFC;
            if (!h && ($urandom % 12) == 0) rs[1:0] = 2'($urandom_range(1, 3));
            drive((m_state != 0) ? (($urandom % 4) != 0) : (($urandom % 60) != 0),
                  ($urandom % 7) == 0, $urandom % 2 == 0, $urandom % 2 == 0,
                  16'($urandom), ($urandom % 5) == 0, 26'($urandom),
                  ($urandom % 6) == 0, rs, h);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end

        chk("wrap_reset_pc", 64'(pc_w), 64'h0000_0000_FFFF_FFFC);
        chk("wrap_pc4", 64'(pc4_w), 64'h0);
        rst_w_n = 1;
        @(posedge clk);
        #1;
        chk("wrap_pc", 64'(pc_w), 64'h0);
        chk("wrap_fault", 64'(fault_w), 64'h0);
        chk("wrap_state", 64'(state_w), 64'h0);
        chk("wrap_retired", 64'(ret_w), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
